// File: rtl/sys_clk_reset_ce_gen.sv
`default_nettype none
// ============================================================================
// Module   : sys_clk_reset_ce_gen
// Brief    : Lock-aware core reset and clock-enable generator on clk_sys.
//            It synchronises pll_locked, holds the core in reset until the
//            lock has been stable for HOLD_CYCLES, and then generates
//            single-cycle enables for the pixel, Z80 and PSG domains.
// Options  : CE_PAUSE_EN - when defined, pause freezes the CPU/PSG enables
//            while running.
// Revision : 1.0 - initial release
// ============================================================================
module sys_clk_reset_ce_gen #(
  parameter int PIX_DIV     = 8,
  parameter int CPU_DIV     = 12,
  parameter int HOLD_CYCLES = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic pll_locked,
  input  logic pause,
  output logic core_reset,
  output logic ce_pix,
  output logic ce_cpu,
  output logic ce_snd2,
  output logic running
);

  localparam int PW = $clog2(PIX_DIV);
  localparam int CW = $clog2(CPU_DIV);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [PW-1:0] PIX_LAST  = PW'(PIX_DIV - 1);
  localparam logic [CW-1:0] CPU_LAST  = CW'(CPU_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lock_s;
  logic [HW-1:0]          hold_q, hold_d;
  logic [PW-1:0]          pix_cnt_q, pix_cnt_d;
  logic [CW-1:0]          cpu_cnt_q, cpu_cnt_d;
  logic                   toggle_q, toggle_d;
  logic                   core_reset_q, core_reset_d;
  logic                   running_q, running_d;
  logic                   ce_pix_q, ce_pix_d;
  logic                   ce_cpu_q, ce_cpu_d;
  logic                   ce_snd2_q, ce_snd2_d;
  logic                   pause_act;
  logic                   pix_wrap;
  logic                   cpu_wrap;

`ifdef CE_PAUSE_EN
  assign pause_act = pause;
`else
  // Port kept for a uniform interface; it has no effect in this build.
  logic unused_pause;
  assign unused_pause = pause;
  assign pause_act    = 1'b0;
`endif

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Lock synchroniser shift and lock-tracking state machine.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pll_locked};
    state_d = state_q;
    hold_d  = '0;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_s) state_d = HOLD;
      end
      HOLD: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (hold_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      RUN: begin
        if (!lock_s) state_d = WAIT_LOCK;
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Dividers and registered outputs; everything is forced idle unless the
  // machine stays in RUN across this edge, so enables die with the lock.
  always_comb begin
    pix_cnt_d    = '0;
    cpu_cnt_d    = '0;
    toggle_d     = 1'b0;
    ce_pix_d     = 1'b0;
    ce_cpu_d     = 1'b0;
    ce_snd2_d    = 1'b0;
    pix_wrap     = (pix_cnt_q == PIX_LAST);
    cpu_wrap     = (cpu_cnt_q == CPU_LAST);
    core_reset_d = (state_d != RUN);
    running_d    = (state_d == RUN);
    if ((state_q == RUN) && (state_d == RUN)) begin
      pix_cnt_d = pix_wrap ? '0 : pix_cnt_q + PW'(1);
      ce_pix_d  = pix_wrap;
      if (pause_act) begin
        cpu_cnt_d = cpu_cnt_q;
        toggle_d  = toggle_q;
      end else begin
        cpu_cnt_d = cpu_wrap ? '0 : cpu_cnt_q + CW'(1);
        ce_cpu_d  = cpu_wrap;
        ce_snd2_d = cpu_wrap & toggle_q;
        toggle_d  = toggle_q ^ cpu_wrap;
      end
    end
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= WAIT_LOCK;
      sync_q       <= '0;
      hold_q       <= '0;
      pix_cnt_q    <= '0;
      cpu_cnt_q    <= '0;
      toggle_q     <= 1'b0;
      core_reset_q <= 1'b1;
      running_q    <= 1'b0;
      ce_pix_q     <= 1'b0;
      ce_cpu_q     <= 1'b0;
      ce_snd2_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      hold_q       <= hold_d;
      pix_cnt_q    <= pix_cnt_d;
      cpu_cnt_q    <= cpu_cnt_d;
      toggle_q     <= toggle_d;
      core_reset_q <= core_reset_d;
      running_q    <= running_d;
      ce_pix_q     <= ce_pix_d;
      ce_cpu_q     <= ce_cpu_d;
      ce_snd2_q    <= ce_snd2_d;
    end
  end

  assign core_reset = core_reset_q;
  assign running    = running_q;
  assign ce_pix     = ce_pix_q;
  assign ce_cpu     = ce_cpu_q;
  assign ce_snd2    = ce_snd2_q;

endmodule
`default_nettype wire
